input_conditioner: RTL
======================

# input_conditioner

Front-end stage between the raw `io_in` pads and the arrival/authorisation FSM. It synchronises the three asynchronous push-button/sensor inputs (C1, C2, I), debounces each one, and presents clean levels plus single-cycle rising-edge pulses. The levels feed the FSM's C1/C2/I inputs directly.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised samples required before a level change is accepted; legal range 2..65535.
- `N_CH`, default 3: number of channels. Channel 0 = C1, 1 = C2, 2 = I.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low; clears every flop.
- `ena`  in  1  block enable (tile enable).
- `raw_i`  in  N_CH  unsynchronised inputs, `io_in[N_CH-1:0]`.
- `lvl_o`  out  N_CH  debounced level per channel.
- `rise_o`  out  N_CH  one-cycle pulse on each accepted 0→1 change of `lvl_o`.

## Operation
Each channel operates independently.
- Reset values: `lvl_o` = 0, `rise_o` = 0, synchroniser flops = 0, counters = 0.
- Synchroniser: two flops, `raw_i` → s1 → s2. They run regardless of `ena`.
- Debounce state per channel: the accepted level `db` (drives `lvl_o`) and a counter `cnt` of width max(1, $clog2(DEBOUNCE_CYCLES)).
- Rules evaluated at each edge:
  - `ena` = 0: `cnt` <= 0, `db` held, no pulse.
  - `ena` = 1, s2 == `db`: `cnt` <= 0. This covers glitches shorter than the threshold, which are discarded.
  - `ena` = 1, s2 != `db`, `cnt` < DEBOUNCE_CYCLES-1: `cnt` <= `cnt`+1.
  - `ena` = 1, s2 != `db`, `cnt` == DEBOUNCE_CYCLES-1: `db` <= s2, `cnt` <= 0. This is an accepted change.
- `rise_o[ch]` is a registered pulse, set on an edge where an accepted change has s2 = 1, and cleared on the following edge. It is high in exactly the first cycle in which `lvl_o[ch]` = 1.
- Falling changes are accepted the same way but produce no pulse.
- Counters never wrap: they saturate into the accept condition and then clear.
- Simultaneous changes on several channels are accepted independently. Multiple `rise_o` bits may assert in the same cycle.

## Timing
- Latency: a `raw_i` level first sampled at edge k gives `lvl_o` changing after edge k+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 edges inclusive. `rise_o` follows the same timing.
- Minimum accepted pulse width is DEBOUNCE_CYCLES cycles at s2. Anything shorter never reaches `lvl_o`.
- Reset mid-count: `rst_n` low immediately zeroes everything, asynchronously. After release, the full DEBOUNCE_CYCLES+2 latency applies again.
- `ena` deasserted mid-count: the count is lost. When `ena` returns, counting restarts from 0, and `lvl_o` keeps its last accepted value meanwhile.
- All outputs come straight from flops, with no combinational path from `raw_i`.

## Configuration
- `INCOND_EDGE_EN` defined: `rise_o` edge-pulse logic is present, as described above.
- `INCOND_EDGE_EN` undefined: the pulse flops are not built and `rise_o` is tied to 0. `lvl_o` behaviour is unchanged.

## Structure
- Package `incond_pkg` holds:
  - `DEBOUNCE_CYCLES_DEF` = 16
  - `N_CH_DEF` = 3
  - channel indices `CH_C1` = 0, `CH_C2` = 1, `CH_I` = 2
- Sub-module `debounce_ch` implements one channel: synchroniser, counter, `db` flop, and optional pulse flop.
- `input_conditioner` instantiates `debounce_ch` N_CH times via generate.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 and `ena` = 1 unless stated.
- Reset: `rst_n` = 0 with `raw_i` = 3'b111 → `lvl_o` = 0 and `rise_o` = 0 throughout. Release, hold `raw_i` → `lvl_o` = 3'b111 after the 6th edge following release, and `rise_o` = 3'b111 for exactly that one cycle.
- Glitch reject: `raw_i[0]` high for 3 cycles, then low → `lvl_o[0]` stays 0 and `rise_o[0]` never asserts.
- Bounce: `raw_i[1]` toggles 1,0,1,1,0, then stays 1 → `lvl_o[1]` rises exactly 6 edges after the final stable 1 is first sampled, with a single `rise_o[1]` pulse.
- Release: `lvl_o[2]` = 1, then `raw_i[2]` goes to 0 → `lvl_o[2]` = 0 after 6 edges and no `rise_o` pulse.
- Enable/reset interruption:
  - `raw_i[0]` high, `ena` dropped after 3 edges for 2 cycles, then restored → `lvl_o[0]` rises 4 edges after `ena` returns.
  - Repeat with `rst_n` pulsed low instead → everything is 0, and the full 6-edge latency applies from release.
- Macro off: build without `INCOND_EDGE_EN` and rerun the first scenario → `lvl_o` identical, `rise_o` constantly 0.

Source files
------------

// File: rtl/incond_pkg.sv
// Shared constants for the input conditioner: default parameters, channel
// indices and the debounce counter width helper.
package incond_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
    localparam int unsigned N_CH_DEF            = 3;

    localparam int unsigned CH_C1 = 0;
    localparam int unsigned CH_C2 = 1;
    localparam int unsigned CH_I  = 2;

    // Counter width needed to count 0..cycles-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One input conditioner channel: two-flop synchroniser, stability counter,
// accepted-level flop and, when INCOND_EDGE_EN is defined, a registered
// rising-edge pulse. Without INCOND_EDGE_EN the pulse output is tied low.
module debounce_ch
    import incond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic raw_i,
    output logic lvl_o,
    output logic rise_o
);

    localparam int unsigned      CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Synchroniser shift path; runs regardless of the block enable.
    always_comb begin
        s1_d = raw_i;
        s2_d = s1_q;
    end

    // Count consecutive samples that disagree with the accepted level; any
    // agreeing sample or a disabled block throws the partial count away.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (ena && (s2_q != db_q)) begin
            if (cnt_q == CNT_MAX) begin
                db_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers for synchroniser, counter and accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign lvl_o = db_q;

`ifdef INCOND_EDGE_EN
    logic rise_q, rise_d;

    // A pulse is due exactly when the accepted level is about to go 0 -> 1.
    always_comb begin
        rise_d = db_d & ~db_q;
    end

    // Pulse register so the pulse lines up with the first high cycle of lvl_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
        end
    end

    assign rise_o = rise_q;
`else
    assign rise_o = 1'b0;
`endif

endmodule

// File: rtl/input_conditioner.sv
// Front-end conditioner for the C1/C2/I pad inputs: one independent
// debounce_ch per channel. Rising-edge pulses exist only when INCOND_EDGE_EN
// is defined; otherwise rise_o reads as all zeros.
module input_conditioner
    import incond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned N_CH            = N_CH_DEF
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic [N_CH-1:0] raw_i,
    output logic [N_CH-1:0] lvl_o,
    output logic [N_CH-1:0] rise_o
);

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .ena    (ena),
            .raw_i  (raw_i[ch]),
            .lvl_o  (lvl_o[ch]),
            .rise_o (rise_o[ch])
        );
    end

endmodule
